// File: rtl/codec_init_sequencer.sv
// codec_init_sequencer
// Power-up configuration sequencer for the audio codec. Walks a fixed
// 12-entry register table and issues one two-byte I2C write per entry,
// inserting the VMID settling delay before activation and retrying NACKed
// writes.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-low reset
//   reinit       one-cycle request to rerun the table (honoured in DONE/ERROR)
//   i2c_ready    byte master idle
//   i2c_done     one-cycle pulse at end of a transfer
//   i2c_nack     NACK seen, valid with i2c_done
//   i2c_start    one-cycle transfer request
//   i2c_dev_addr 7-bit codec device address
//   i2c_byte0    {reg_addr[6:0], reg_data[8]}
//   i2c_byte1    reg_data[7:0]
//   busy         sequence in progress
//   init_done    all entries written (sticky)
//   init_error   retries exhausted (sticky)
//   step_index   current table entry, 0..11
`timescale 1ns/1ps
module codec_init_sequencer #(
  parameter logic [6:0]  I2C_DEV_ADDR     = 7'h1A,
  parameter logic [31:0] VMID_WAIT_CYCLES = 32'd6_250_000,
  parameter logic [15:0] RETRY_GAP_CYCLES = 16'd1250,
  parameter logic [1:0]  MAX_RETRIES      = 2'd3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       reinit,
  input  logic       i2c_ready,
  input  logic       i2c_done,
  input  logic       i2c_nack,
  output logic       i2c_start,
  output logic [6:0] i2c_dev_addr,
  output logic [7:0] i2c_byte0,
  output logic [7:0] i2c_byte1,
  output logic       busy,
  output logic       init_done,
  output logic       init_error,
  output logic [3:0] step_index
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT_ACK,
    S_DELAY,
    S_DONE,
    S_ERROR
  } state_t;

  state_t      state;
  logic [1:0]  retry_cnt;
  logic [31:0] delay_cnt;
  logic [6:0]  entry_reg;
  logic [8:0]  entry_data;

  assign i2c_dev_addr = I2C_DEV_ADDR;

  // Register table
  always_comb begin
    entry_reg  = '0;
    entry_data = '0;
    case (step_index)
      4'd0:  begin entry_reg = 7'h0F; entry_data = 9'h000; end
      4'd1:  begin entry_reg = 7'h06; entry_data = 9'h072; end
      4'd2:  begin entry_reg = 7'h00; entry_data = 9'h017; end
      4'd3:  begin entry_reg = 7'h01; entry_data = 9'h017; end
      4'd4:  begin entry_reg = 7'h02; entry_data = 9'h079; end
      4'd5:  begin entry_reg = 7'h03; entry_data = 9'h079; end
      4'd6:  begin entry_reg = 7'h04; entry_data = 9'h010; end
      4'd7:  begin entry_reg = 7'h05; entry_data = 9'h000; end
      4'd8:  begin entry_reg = 7'h07; entry_data = 9'h00A; end
      4'd9:  begin entry_reg = 7'h08; entry_data = 9'h000; end
      4'd10: begin entry_reg = 7'h09; entry_data = 9'h001; end
      4'd11: begin entry_reg = 7'h06; entry_data = 9'h062; end
      default: begin entry_reg = '0; entry_data = '0; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      i2c_start  <= 1'b0;
      i2c_byte0  <= '0;
      i2c_byte1  <= '0;
      busy       <= 1'b0;
      init_done  <= 1'b0;
      init_error <= 1'b0;
      step_index <= '0;
      retry_cnt  <= '0;
      delay_cnt  <= '0;
    end else begin
      i2c_start <= 1'b0;
      case (state)
        S_IDLE: begin
          state <= S_LOAD;
          busy  <= 1'b1;
        end
        S_LOAD: begin
          i2c_byte0 <= {entry_reg, entry_data[8]};
          i2c_byte1 <= entry_data[7:0];
          retry_cnt <= '0;
          // LOAD is only entered on a first attempt; retries re-enter at ISSUE
          if (step_index == 4'd10) begin
            delay_cnt <= VMID_WAIT_CYCLES;
            state     <= S_DELAY;
          end else begin
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (i2c_ready) begin
            i2c_start <= 1'b1;
            state     <= S_WAIT_ACK;
          end
        end
        S_WAIT_ACK: begin
          if (i2c_done) begin
            if (!i2c_nack) begin
              if (step_index == 4'd11) begin
                state     <= S_DONE;
                busy      <= 1'b0;
                init_done <= 1'b1;
              end else begin
                step_index <= step_index + 4'd1;
                state      <= S_LOAD;
              end
            end else if (retry_cnt < MAX_RETRIES) begin
              retry_cnt <= retry_cnt + 2'd1;
              delay_cnt <= {16'd0, RETRY_GAP_CYCLES};
              state     <= S_DELAY;
            end else begin
              state      <= S_ERROR;
              busy       <= 1'b0;
              init_error <= 1'b1;
            end
          end
        end
        S_DELAY: begin
          // A loaded count of N keeps the FSM here for N cycles
          if (delay_cnt <= 32'd1) begin
            state <= S_ISSUE;
          end else begin
            delay_cnt <= delay_cnt - 32'd1;
          end
        end
        S_DONE, S_ERROR: begin
          if (reinit) begin
            init_done  <= 1'b0;
            init_error <= 1'b0;
            step_index <= '0;
            busy       <= 1'b1;
            state      <= S_LOAD;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_codec_init_sequencer.sv
// Testbench for codec_init_sequencer: a behavioural I2C byte master with
// random transfer lengths, stray reinit/done pulses and configurable NACKs,
// checked against a table-driven reference of the expected write sequence.
`timescale 1ns/1ps
module tb_codec_init_sequencer;

  localparam int VMID = 100;
  localparam int RGAP = 20;
  localparam int MAXR = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       reinit;
  logic       i2c_ready;
  logic       i2c_done;
  logic       i2c_nack;
  logic       i2c_start;
  logic [6:0] i2c_dev_addr;
  logic [7:0] i2c_byte0;
  logic [7:0] i2c_byte1;
  logic       busy;
  logic       init_done;
  logic       init_error;
  logic [3:0] step_index;

  always #5 clk = ~clk;

  codec_init_sequencer #(
    .I2C_DEV_ADDR    (7'h1A),
    .VMID_WAIT_CYCLES(32'(VMID)),
    .RETRY_GAP_CYCLES(16'(RGAP)),
    .MAX_RETRIES     (2'(MAXR))
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .reinit      (reinit),
    .i2c_ready   (i2c_ready),
    .i2c_done    (i2c_done),
    .i2c_nack    (i2c_nack),
    .i2c_start   (i2c_start),
    .i2c_dev_addr(i2c_dev_addr),
    .i2c_byte0   (i2c_byte0),
    .i2c_byte1   (i2c_byte1),
    .busy        (busy),
    .init_done   (init_done),
    .init_error  (init_error),
    .step_index  (step_index)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tbl_reg  [12] = '{'h0F, 'h06, 'h00, 'h01, 'h02, 'h03, 'h04, 'h05, 'h07, 'h08, 'h09, 'h06};
  int tbl_data [12] = '{'h000, 'h072, 'h017, 'h017, 'h079, 'h079, 'h010, 'h000, 'h00A, 'h000, 'h001, 'h062};

  function automatic logic [7:0] exp_b0(int i);
    return 8'(tbl_reg[i] * 2 + tbl_data[i] / 256);
  endfunction
  function automatic logic [7:0] exp_b1(int i);
    return 8'(tbl_data[i] % 256);
  endfunction
  function automatic int lookup(logic [7:0] b0, logic [7:0] b1);
    for (int i = 0; i < 12; i++)
      if (b0 == exp_b0(i) && b1 == exp_b1(i)) return i;
    return -1;
  endfunction

  // Master control and logs
  bit         hold_ready = 0;
  bit         reinit_req = 0;
  int         nack_entry = -1;
  int         nack_cnt = 0;
  int         nack_seen = 0;
  int         start_viol = 0;
  logic [7:0] log_b0 [$];
  logic [7:0] log_b1 [$];
  int         log_cyc [$];
  int         done_cyc [$];

  bit busy_m;
  int remain;
  bit nack_now;
  int m_idx;

  initial begin
    i2c_ready = 1'b1; i2c_done = 1'b0; i2c_nack = 1'b0; reinit = 1'b0;
    busy_m = 0; remain = 0; nack_now = 0;
    forever begin
      @(negedge clk);
      i2c_done = 1'b0;
      i2c_nack = 1'b0;
      reinit   = 1'b0;
      if (!reset) begin
        busy_m = 0;
        i2c_ready = !hold_ready;
        continue;
      end
      if (i2c_start) begin
        if (!i2c_ready || busy_m) start_viol++;
        m_idx = lookup(i2c_byte0, i2c_byte1);
        log_b0.push_back(i2c_byte0);
        log_b1.push_back(i2c_byte1);
        log_cyc.push_back(cyc);
        nack_now = (m_idx == nack_entry) && (nack_seen < nack_cnt);
        if (nack_now) nack_seen++;
        busy_m = 1;
        remain = $urandom_range(5, 25);
      end else if (busy_m) begin
        remain--;
        if (remain == 0) begin
          i2c_done = 1'b1;
          i2c_nack = nack_now;
          busy_m = 0;
          done_cyc.push_back(cyc);
          if ($urandom_range(0, 1) == 1) reinit = 1'b1;
        end else begin
          i2c_nack = 1'($urandom_range(0, 1));
          if ($urandom_range(0, 9) == 0) reinit = 1'b1;
        end
      end else if ($urandom_range(0, 9) == 0) begin
        // spurious done while the sequencer is not waiting for one
        i2c_done = 1'b1;
        i2c_nack = 1'($urandom_range(0, 1));
      end
      if (reinit_req) begin
        reinit = 1'b1;
        reinit_req = 0;
      end
      i2c_ready = !busy_m && !hold_ready;
    end
  end

  // Reference model: expected entry per start and start latency
  int exp_idx [$];
  int exp_lat [$];
  bit exp_err;
  int exp_step;

  task automatic build_expected(int ne, int nc);
    int n, tries;
    exp_idx.delete(); exp_lat.delete();
    exp_err = 0; exp_step = 11;
    for (int e = 0; e < 12; e++) begin
      n = (e == ne) ? nc : 0;
      tries = (n > MAXR) ? MAXR + 1 : n + 1;
      for (int a = 0; a < tries; a++) begin
        exp_idx.push_back(e);
        if (a > 0) exp_lat.push_back(2 + RGAP);
        else if (e == 10) exp_lat.push_back(3 + VMID);
        else exp_lat.push_back(3);
      end
      if (n > MAXR) begin
        exp_err = 1; exp_step = e;
        break;
      end
    end
  endtask

  task automatic clear_logs();
    log_b0.delete(); log_b1.delete(); log_cyc.delete(); done_cyc.delete();
    start_viol = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    tests++; if (i2c_start !== 1'b0) begin fails++; $display("FAIL reset_start got %b exp 0", i2c_start); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
    tests++; if (init_done !== 1'b0) begin fails++; $display("FAIL reset_done got %b exp 0", init_done); end
    tests++; if (init_error !== 1'b0) begin fails++; $display("FAIL reset_error got %b exp 0", init_error); end
    tests++; if (step_index !== 4'd0) begin fails++; $display("FAIL reset_step got %0d exp 0", step_index); end
    tests++; if (i2c_byte0 !== 8'h00 || i2c_byte1 !== 8'h00) begin fails++; $display("FAIL reset_bytes got %h %h exp 00 00", i2c_byte0, i2c_byte1); end
    tests++; if (i2c_dev_addr !== 7'h1A) begin fails++; $display("FAIL reset_addr got %h exp 1a", i2c_dev_addr); end
  endtask

  task automatic test_sequence(string name, int ne, int nc, bit via_reinit);
    int t0, prev, ei;
    bit got;
    build_expected(ne, nc);
    @(posedge clk); #1;
    nack_entry = ne; nack_cnt = nc; nack_seen = 0;
    hold_ready = 0;
    clear_logs();
    if (via_reinit) begin
      t0 = cyc;
      reinit_req = 1;
    end else begin
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      t0 = cyc;
    end
    got = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (log_b0.size() > 0) begin got = 1; break; end
    end
    tests++; if (!got) begin fails++; $display("FAIL %s first_start timeout got none exp start", name); end
    tests++; if (init_done !== 1'b0 || init_error !== 1'b0) begin
      fails++; $display("FAIL %s flags_cleared got done=%b err=%b exp 0 0", name, init_done, init_error);
    end
    got = 0;
    for (int k = 0; k < 20000; k++) begin
      @(negedge clk);
      if (init_done || init_error) begin got = 1; break; end
    end
    tests++; if (!got) begin fails++; $display("FAIL %s completion timeout got busy=%b exp done/error", name, busy); end
    repeat (100) @(posedge clk);
    #1;
    tests++; if (log_b0.size() != exp_idx.size()) begin
      fails++; $display("FAIL %s start_count got %0d exp %0d", name, log_b0.size(), exp_idx.size());
    end
    for (int i = 0; i < log_b0.size() && i < exp_idx.size(); i++) begin
      ei = exp_idx[i];
      tests++; if (log_b0[i] !== exp_b0(ei) || log_b1[i] !== exp_b1(ei)) begin
        fails++; $display("FAIL %s bytes[%0d] got %h %h exp %h %h", name, i, log_b0[i], log_b1[i], exp_b0(ei), exp_b1(ei));
      end
      prev = (i == 0) ? t0 : ((i - 1 < done_cyc.size()) ? done_cyc[i - 1] : -100000);
      tests++; if (log_cyc[i] - prev != exp_lat[i]) begin
        fails++; $display("FAIL %s latency[%0d] got %0d exp %0d", name, i, log_cyc[i] - prev, exp_lat[i]);
      end
    end
    tests++; if (init_done !== !exp_err || init_error !== exp_err) begin
      fails++; $display("FAIL %s final_flags got done=%b err=%b exp done=%b err=%b", name, init_done, init_error, !exp_err, exp_err);
    end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL %s final_busy got %b exp 0", name, busy); end
    tests++; if (step_index !== 4'(exp_step)) begin fails++; $display("FAIL %s final_step got %0d exp %0d", name, step_index, exp_step); end
    tests++; if (start_viol != 0) begin fails++; $display("FAIL %s start_protocol got %0d violations exp 0", name, start_viol); end
  endtask

  task automatic test_ready_hold();
    int rel;
    bit got;
    @(posedge clk); #1;
    nack_entry = -1; nack_cnt = 0; nack_seen = 0;
    hold_ready = 1;
    reset = 1'b0;
    clear_logs();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (500) @(posedge clk);
    #1;
    tests++; if (log_b0.size() != 0) begin fails++; $display("FAIL ready_hold no_start got %0d starts exp 0", log_b0.size()); end
    tests++; if (busy !== 1'b1 || step_index !== 4'd0) begin
      fails++; $display("FAIL ready_hold state got busy=%b step=%0d exp 1 0", busy, step_index);
    end
    hold_ready = 0;
    rel = cyc;
    got = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (log_b0.size() > 0) begin got = 1; break; end
    end
    tests++; if (!got || log_cyc[0] != rel + 1) begin
      fails++; $display("FAIL ready_hold release_latency got %0d exp %0d", got ? log_cyc[0] - rel : -1, 1);
    end
    got = 0;
    for (int k = 0; k < 20000; k++) begin
      @(negedge clk);
      if (init_done) begin got = 1; break; end
    end
    tests++; if (!got || log_b0.size() != 12) begin
      fails++; $display("FAIL ready_hold completion got done=%b starts=%0d exp 1 12", init_done, log_b0.size());
    end
  endtask

  task automatic test_reset_mid_transfer();
    int t0;
    bit got;
    @(posedge clk); #1;
    nack_entry = -1; nack_cnt = 0; nack_seen = 0;
    hold_ready = 0;
    reset = 1'b0;
    clear_logs();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    got = 0;
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (log_b0.size() >= 6) begin got = 1; break; end
    end
    tests++; if (!got || log_b0[5] !== exp_b0(5)) begin
      fails++; $display("FAIL reset_mid reach_entry5 got %0d starts exp 6", log_b0.size());
    end
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    tests++; if (i2c_start !== 1'b0 || busy !== 1'b0 || init_done !== 1'b0 || init_error !== 1'b0) begin
      fails++; $display("FAIL reset_mid flags got start=%b busy=%b done=%b err=%b exp 0 0 0 0", i2c_start, busy, init_done, init_error);
    end
    tests++; if (step_index !== 4'd0 || i2c_byte0 !== 8'h00 || i2c_byte1 !== 8'h00) begin
      fails++; $display("FAIL reset_mid regs got step=%0d bytes=%h %h exp 0 00 00", step_index, i2c_byte0, i2c_byte1);
    end
    clear_logs();
    @(posedge clk);
    #1 reset = 1'b1;
    t0 = cyc;
    got = 0;
    for (int k = 0; k < 20000; k++) begin
      @(negedge clk);
      if (init_done) begin got = 1; break; end
    end
    tests++; if (log_b0.size() == 0 || log_b0[0] !== 8'h1E || log_b1[0] !== 8'h00 || log_cyc[0] != t0 + 3) begin
      fails++; $display("FAIL reset_mid restart got %0d starts first_cyc_off=%0d exp entry0 at 3",
                        log_b0.size(), (log_cyc.size() > 0) ? log_cyc[0] - t0 : -1);
    end
    tests++; if (!got || log_b0.size() != 12) begin
      fails++; $display("FAIL reset_mid completion got done=%b starts=%0d exp 1 12", init_done, log_b0.size());
    end
  endtask

  initial begin
    test_reset();
    test_sequence("full_ack", -1, 0, 0);
    test_sequence("nack2_entry3", 3, 2, 0);
    test_sequence("rand_retry", int'($urandom_range(0, 11)), int'($urandom_range(1, 3)), 0);
    test_sequence("error_entry0", 0, 99, 0);
    test_sequence("reinit_from_error", -1, 0, 1);
    test_sequence("reinit_from_done", int'($urandom_range(0, 11)), int'($urandom_range(1, 4)), 1);
    test_ready_hold();
    test_reset_mid_transfer();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
